// File: rtl/alarm_pkg.sv
// Shared definitions for the time/alarm entry controller: state codes,
// BCD field limits and field increment helpers.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLK_H  = 3'd1,
        ST_CLK_M  = 3'd2,
        ST_ALM_H  = 3'd3,
        ST_ALM_M  = 3'd4,
        ST_DUR    = 3'd5,
        ST_COMMIT = 3'd6
    } state_e;

    localparam logic [7:0] HOUR_MAX    = 8'h23;
    localparam logic [7:0] MIN_MAX     = 8'h59;
    localparam logic [3:0] DUR_MAX     = 4'd15;
    localparam logic [3:0] DUR_MIN     = 4'd1;
    localparam logic [3:0] DUR_DEFAULT = 4'd1;

    // Two-digit BCD increment, wrapping to 00 once lim has been reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v >= lim) begin
            r = 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [3:0] dur_inc(input logic [3:0] d);
        logic [3:0] r;
        if (d >= DUR_MAX) begin
            r = DUR_MIN;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability debounce and
// a single-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);
    localparam int            CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    // The counter runs only while the synchronised input disagrees with the
    // debounced level; any agreeing cycle restarts the stability window.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q >= CNT_MAX) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/time_entry.sv
// Three-button clock preset / alarm time / alarm duration entry controller.
//   state  | meaning
//   IDLE   | not editing; inc silences the alarm
//   CLK_H  | editing clock hours      CLK_M | editing clock minutes
//   ALM_H  | editing alarm hours      ALM_M | editing alarm minutes
//   DUR    | editing alarm duration   COMMIT| one cycle, shadows published
module time_entry
    import alarm_pkg::*;
#(
    parameter int DEB_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic [15:0] Clock,
    output logic [15:0] set_Clock,
    output logic [15:0] set_Alarm,
    output logic [3:0]  dur_Alarm,
    output logic        load_Clock,
    output logic        off_Alarm,
    output logic [2:0]  edit_field
);
    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic          mode_rise, next_rise, inc_rise;
    logic          ev_mode, ev_next, ev_inc;
    state_e        state_q, state_d;
    logic [15:0]   sh_clk_q, sh_clk_d;
    logic [15:0]   sh_alm_q, sh_alm_d;
    logic [3:0]    sh_dur_q, sh_dur_d;
    logic [15:0]   set_clk_q, set_clk_d;
    logic [15:0]   set_alm_q, set_alm_d;
    logic [3:0]    dur_q, dur_d;
    logic          load_q, load_d;
    logic          off_q, off_d;
    logic [TW-1:0] tmo_q, tmo_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_mode),
        .rise_o (mode_rise)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_next),
        .rise_o (next_rise)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_inc),
        .rise_o (inc_rise)
    );

    // Coincident edges: mode beats next beats inc; losers are dropped.
    assign ev_mode = mode_rise;
    assign ev_next = next_rise & ~mode_rise;
    assign ev_inc  = inc_rise & ~mode_rise & ~next_rise;

    always_comb begin
        state_d   = state_q;
        sh_clk_d  = sh_clk_q;
        sh_alm_d  = sh_alm_q;
        sh_dur_d  = sh_dur_q;
        set_clk_d = set_clk_q;
        set_alm_d = set_alm_q;
        dur_d     = dur_q;
        load_d    = 1'b0;
        off_d     = 1'b0;
        tmo_d     = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ev_mode) begin
                    state_d  = ST_CLK_H;
                    sh_clk_d = Clock;
                    sh_alm_d = set_alm_q;
                    sh_dur_d = dur_q;
                    tmo_d    = TMO_LOAD;
                end else if (ev_inc) begin
                    off_d = 1'b1;
                end
            end
            ST_CLK_H, ST_CLK_M, ST_ALM_H, ST_ALM_M, ST_DUR: begin
                if (ev_mode || (tmo_q == '0)) begin
                    state_d = ST_IDLE;
                end else if (ev_next) begin
                    tmo_d = TMO_LOAD;
                    unique case (state_q)
                        ST_CLK_H: state_d = ST_CLK_M;
                        ST_CLK_M: state_d = ST_ALM_H;
                        ST_ALM_H: state_d = ST_ALM_M;
                        ST_ALM_M: state_d = ST_DUR;
                        default: begin
                            // Publish on entry so the new values and the
                            // load strobe are both visible during COMMIT.
                            state_d   = ST_COMMIT;
                            set_clk_d = sh_clk_q;
                            set_alm_d = sh_alm_q;
                            dur_d     = sh_dur_q;
                            load_d    = 1'b1;
                        end
                    endcase
                end else if (ev_inc) begin
                    tmo_d = TMO_LOAD;
                    unique case (state_q)
                        ST_CLK_H: sh_clk_d[15:8] = bcd_inc(sh_clk_q[15:8], HOUR_MAX);
                        ST_CLK_M: sh_clk_d[7:0]  = bcd_inc(sh_clk_q[7:0], MIN_MAX);
                        ST_ALM_H: sh_alm_d[15:8] = bcd_inc(sh_alm_q[15:8], HOUR_MAX);
                        ST_ALM_M: sh_alm_d[7:0]  = bcd_inc(sh_alm_q[7:0], MIN_MAX);
                        default:  sh_dur_d       = dur_inc(sh_dur_q);
                    endcase
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sh_clk_q  <= 16'h0000;
            sh_alm_q  <= 16'h0000;
            sh_dur_q  <= DUR_DEFAULT;
            set_clk_q <= 16'h0000;
            set_alm_q <= 16'h0000;
            dur_q     <= DUR_DEFAULT;
            load_q    <= 1'b0;
            off_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            sh_clk_q  <= sh_clk_d;
            sh_alm_q  <= sh_alm_d;
            sh_dur_q  <= sh_dur_d;
            set_clk_q <= set_clk_d;
            set_alm_q <= set_alm_d;
            dur_q     <= dur_d;
            load_q    <= load_d;
            off_q     <= off_d;
            tmo_q     <= tmo_d;
        end
    end

    assign set_Clock  = set_clk_q;
    assign set_Alarm  = set_alm_q;
    assign dur_Alarm  = dur_q;
    assign load_Clock = load_q;
    assign off_Alarm  = off_q;
    assign edit_field = state_q;

endmodule
